bsg_link_sdr_reset_sequencer: RTL and testbench

Generates the four-phase reset sequence for a chain of `bsg_link_sdr` based manycore SDR link nodes: uplink, downlink, downstream and token reset. It drives `async_uplink_reset_o`, `async_downlink_reset_o`, `async_downstream_reset_o` and `async_token_reset_o` in the fixed order the SDR link requires, with programmable dwell times. A single sequencer sits at the head of the reset daisy-chain in the SDR column/row. Software can re-run the sequence with `start_i`.

---
 rtl/bsg_link_sdr_reset_sequencer.sv | 111 +++++++++++
 tb/tb_bsg_link_sdr_reset_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_sdr_reset_sequencer.sv
// bsg_link_sdr_reset_sequencer
//
// Drives the four-phase reset sequence for a chain of SDR link nodes.
// The phases run in a fixed order, each with a programmable dwell time:
//   ASSERT -> TOKEN -> TOKEN_SETTLE -> UPLINK -> DOWNLINK -> DONE
//
// Ports:
//   clk_i                    core clock (only clock)
//   reset_i                  synchronous, active-high reset
//   start_i                  re-run request, honoured only in DONE
//   async_uplink_reset_o     uplink reset (registered)
//   async_downlink_reset_o   downlink reset (registered)
//   async_downstream_reset_o downstream reset (registered)
//   async_token_reset_o      token reset pulse (registered)
//   done_o                   high while in DONE
//   state_o                  current state encoding, for debug
//
// Handshake: start_i is a level-sampled request with no ready/ack. It is
// consumed on any edge where the FSM is in DONE and is dropped (not
// queued) in every other state.
module bsg_link_sdr_reset_sequencer #(
  parameter int wait_cycles_p  = 16,
  parameter int token_cycles_p = 8,
  localparam int max_cycles_lp = (wait_cycles_p > token_cycles_p)
                                 ? wait_cycles_p : token_cycles_p,
  localparam int cnt_width_lp  = $clog2(max_cycles_lp + 1)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       async_uplink_reset_o,
  output logic       async_downlink_reset_o,
  output logic       async_downstream_reset_o,
  output logic       async_token_reset_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] st_assert_lp       = 3'd0;
  localparam logic [2:0] st_token_lp        = 3'd1;
  localparam logic [2:0] st_token_settle_lp = 3'd2;
  localparam logic [2:0] st_uplink_lp       = 3'd3;
  localparam logic [2:0] st_downlink_lp     = 3'd4;
  localparam logic [2:0] st_done_lp         = 3'd5;

  // Terminal counts: a phase of N cycles ends on the edge where cnt == N-1.
  localparam logic [cnt_width_lp-1:0] wait_last_lp  = cnt_width_lp'(wait_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] token_last_lp = cnt_width_lp'(token_cycles_p - 1);

  // Output vector order: uplink, downlink, downstream, token, done.
  localparam logic [4:0] out_reset_lp = 5'b11100;

  logic [2:0]              state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [4:0]              out_q, out_d;

  // Next-state and dwell counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_width_lp'(1);
    case (state_q)
      st_assert_lp:       if (cnt_q == wait_last_lp)  state_d = st_token_lp;
      st_token_lp:        if (cnt_q == token_last_lp) state_d = st_token_settle_lp;
      st_token_settle_lp: if (cnt_q == wait_last_lp)  state_d = st_uplink_lp;
      st_uplink_lp:       if (cnt_q == wait_last_lp)  state_d = st_downlink_lp;
      st_downlink_lp:     if (cnt_q == wait_last_lp)  state_d = st_done_lp;
      st_done_lp: begin
        cnt_d = '0;
        if (start_i) state_d = st_assert_lp;
      end
      default:            state_d = st_assert_lp;
    endcase
    // Every phase starts counting from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they switch on the same
  // edge as the state register without any path from the inputs.
  always_comb begin
    out_d = out_reset_lp;
    case (state_d)
      st_assert_lp:       out_d = 5'b11100;
      st_token_lp:        out_d = 5'b11110;
      st_token_settle_lp: out_d = 5'b11100;
      st_uplink_lp:       out_d = 5'b01100;
      st_downlink_lp:     out_d = 5'b00100;
      st_done_lp:         out_d = 5'b00001;
      default:            out_d = out_reset_lp;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= st_assert_lp;
      cnt_q   <= '0;
      out_q   <= out_reset_lp;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign async_uplink_reset_o     = out_q[4];
  assign async_downlink_reset_o   = out_q[3];
  assign async_downstream_reset_o = out_q[2];
  assign async_token_reset_o      = out_q[1];
  assign done_o                   = out_q[0];
  assign state_o                  = state_q;

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
module tb_bsg_link_sdr_reset_sequencer;

  localparam int wa = 16;
  localparam int ta = 8;
  localparam int wb = 1;
  localparam int tb = 1;
  localparam int len_a = 4 * wa + ta;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset  = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic sva_en = 1'b0;

  logic       up_a, dn_a, ds_a, tok_a, done_a;
  logic [2:0] state_a;
  logic       up_b, dn_b, ds_b, tok_b, done_b;
  logic [2:0] state_b;

  bsg_link_sdr_reset_sequencer #(.wait_cycles_p(wa), .token_cycles_p(ta)) dut_a (
    .clk_i                   (clk),
    .reset_i                 (reset),
    .start_i                 (start_a),
    .async_uplink_reset_o    (up_a),
    .async_downlink_reset_o  (dn_a),
    .async_downstream_reset_o(ds_a),
    .async_token_reset_o     (tok_a),
    .done_o                  (done_a),
    .state_o                 (state_a)
  );

  bsg_link_sdr_reset_sequencer #(.wait_cycles_p(wb), .token_cycles_p(tb)) dut_b (
    .clk_i                   (clk),
    .reset_i                 (reset),
    .start_i                 (start_b),
    .async_uplink_reset_o    (up_b),
    .async_downlink_reset_o  (dn_b),
    .async_downstream_reset_o(ds_b),
    .async_token_reset_o     (tok_b),
    .done_o                  (done_b),
    .state_o                 (state_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Expected {state, up, dn, ds, tok, done} at edge e after release,
  // from the published edge timing (e = 0 means the reset/restart edge).
  function automatic logic [7:0] exp_vec(int e, int w, int t);
    logic [2:0] s;
    if      (e < w)         s = 3'd0;
    else if (e < w + t)     s = 3'd1;
    else if (e < 2 * w + t) s = 3'd2;
    else if (e < 3 * w + t) s = 3'd3;
    else if (e < 4 * w + t) s = 3'd4;
    else                    s = 3'd5;
    case (s)
      3'd0:    return {s, 5'b11100};
      3'd1:    return {s, 5'b11110};
      3'd2:    return {s, 5'b11100};
      3'd3:    return {s, 5'b01100};
      3'd4:    return {s, 5'b00100};
      default: return {s, 5'b00001};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int e, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d observed st/up/dn/ds/tok/done=%b required=%b", tag, e, obs, exp);
    end
  endtask

  function automatic logic [7:0] obs_a();
    return {state_a, up_a, dn_a, ds_a, tok_a, done_a};
  endfunction

  function automatic logic [7:0] obs_b();
    return {state_b, up_b, dn_b, ds_b, tok_b, done_b};
  endfunction

  task automatic run_seq(input string tag, input int first, input int last, input bit chk_b);
    for (int e = first; e <= last; e++) begin
      step();
      check({tag, "_a"}, e, obs_a(), exp_vec(e, wa, ta));
      if (chk_b && e <= 8) check({tag, "_b"}, e, obs_b(), exp_vec(e, wb, tb));
    end
  endtask

  // ---------------- invariant checkers ----------------
  a_tok_a: assert property (@(posedge clk) disable iff (!sva_en)
    tok_a |-> (up_a && dn_a && ds_a))
    else begin n_fail++; $error("FAIL sva_tok_a token high with a reset low"); end
  a_dn_a: assert property (@(posedge clk) disable iff (!sva_en)
    $fell(dn_a) |-> !up_a)
    else begin n_fail++; $error("FAIL sva_dn_a downlink fell before uplink"); end
  a_ds_a: assert property (@(posedge clk) disable iff (!sva_en)
    $fell(ds_a) |-> !dn_a)
    else begin n_fail++; $error("FAIL sva_ds_a downstream fell before downlink"); end
  a_tok_b: assert property (@(posedge clk) disable iff (!sva_en)
    tok_b |-> (up_b && dn_b && ds_b))
    else begin n_fail++; $error("FAIL sva_tok_b token high with a reset low"); end
  a_dn_b: assert property (@(posedge clk) disable iff (!sva_en)
    $fell(dn_b) |-> !up_b)
    else begin n_fail++; $error("FAIL sva_dn_b downlink fell before uplink"); end
  a_ds_b: assert property (@(posedge clk) disable iff (!sva_en)
    $fell(ds_b) |-> !dn_b)
    else begin n_fail++; $error("FAIL sva_ds_b downstream fell before downlink"); end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state.
    reset = 1'b1;
    step();
    step();
    step();
    check("reset_a", 0, obs_a(), exp_vec(0, wa, ta));
    check("reset_b", 0, obs_b(), exp_vec(0, wb, tb));
    sva_en = 1'b1;

    // Power-on: both W=16/T=8 and W=1/T=1 from the same release edge.
    reset = 1'b0;
    run_seq("poweron", 1, len_a, 1'b1);

    // Restart: one-cycle start pulse in DONE.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("restart_edge", 0, obs_a(), exp_vec(0, wa, ta));
    run_seq("restart", 1, len_a, 1'b0);

    // Ignored start: start held high through a whole sequence.
    start_a = 1'b1;
    reset   = 1'b1;
    step();
    check("ign_reset_a", 0, obs_a(), exp_vec(0, wa, ta));
    reset = 1'b0;
    run_seq("ignstart", 1, len_a, 1'b1);
    // Still high once DONE is reached: restarts on the next edge.
    step();
    start_a = 1'b0;
    check("ign_restart", 0, obs_a(), exp_vec(0, wa, ta));

    // Mid-sequence reset in TOKEN with cnt = 3.
    run_seq("pre_mid", 1, wa + 3, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_a", 0, obs_a(), exp_vec(0, wa, ta));
    check("mid_reset_b", 0, obs_b(), exp_vec(0, wb, tb));
    run_seq("post_mid", 1, len_a, 1'b1);

    // Random start/reset traffic under the invariant checkers.
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      start_a = ($urandom_range(0, 15) == 0);
      start_b = ($urandom_range(0, 7) == 0);
      step();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    reset   = 1'b1;
    step();
    check("final_reset_a", 0, obs_a(), exp_vec(0, wa, ta));
    check("final_reset_b", 0, obs_b(), exp_vec(0, wb, tb));
    sva_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
